stopwatch_ctrl: RTL

//  Control FSM and count datapath for the two-digit seconds stopwatch (00-99).

---
 rtl/stopwatch_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Two-digit (00-99) seconds stopwatch: button edge detect, run/pause/lap FSM,
// 1 s prescaler and BCD count datapath with a lap snapshot for the display.
// Optional build macro SW_SATURATE_EN: the count stops at 99 and the state is
// forced to PAUSE instead of rolling over to 00 with a wrap pulse.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       fastclock,
  input  logic       resetn,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] disp_ones,
  output logic [3:0] disp_tens,
  output logic [3:0] live_ones,
  output logic [3:0] live_tens,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  localparam int unsigned DW = 4;
  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [DW-1:0] ones, ones_nxt;
  logic [DW-1:0] tens, tens_nxt;
  logic [DW-1:0] snap_ones, snap_ones_nxt;
  logic [DW-1:0] snap_tens, snap_tens_nxt;
  logic          wrap_nxt;
  logic          ss_prev, lap_prev, clr_prev;
  logic          ss_rise, lap_rise, clr_rise;
  logic          counting, tick;

  // Rising-edge detect on the level buttons and the gated one-second tick
  always_comb begin
    ss_rise  = start_stop & ~ss_prev;
    lap_rise = lap & ~lap_prev;
    clr_rise = clear & ~clr_prev;
    counting = (state == S_RUN) || (state == S_LAP);
    tick     = counting && (presc == PMAX);
  end

  // Next state, prescaler, digit and snapshot values
  always_comb begin
    state_nxt     = state;
    presc_nxt     = presc;
    ones_nxt      = ones;
    tens_nxt      = tens;
    snap_ones_nxt = snap_ones;
    snap_tens_nxt = snap_tens;
    wrap_nxt      = 1'b0;

    // Button priority is clear, then start_stop, then lap
    case (state)
      S_IDLE: begin
        if (ss_rise) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (clr_rise)     state_nxt = S_IDLE;
        else if (ss_rise) state_nxt = S_PAUSE;
        else if (lap_rise) begin
          state_nxt     = S_LAP;
          snap_ones_nxt = ones;
          snap_tens_nxt = tens;
        end
      end
      S_PAUSE: begin
        if (clr_rise)     state_nxt = S_IDLE;
        else if (ss_rise) state_nxt = S_RUN;
      end
      S_LAP: begin
        if (clr_rise)      state_nxt = S_IDLE;
        else if (ss_rise)  state_nxt = S_PAUSE;
        else if (lap_rise) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Prescaler only advances while counting; PAUSE keeps the partial second
    if (counting) presc_nxt = tick ? '0 : presc + PW'(1);

    // A tick is dropped when the same edge leaves the counting states
    if (tick && ((state_nxt == S_RUN) || (state_nxt == S_LAP))) begin
      if (ones != DW'(9)) begin
        ones_nxt = ones + DW'(1);
      end else if (tens != DW'(9)) begin
        ones_nxt = '0;
        tens_nxt = tens + DW'(1);
      end else begin
`ifdef SW_SATURATE_EN
        state_nxt = S_PAUSE;
`else
        ones_nxt = '0;
        tens_nxt = '0;
        wrap_nxt = 1'b1;
`endif
      end
    end

    // Entering or staying in IDLE clears the whole datapath
    if (state_nxt == S_IDLE) begin
      presc_nxt     = '0;
      ones_nxt      = '0;
      tens_nxt      = '0;
      snap_ones_nxt = '0;
      snap_tens_nxt = '0;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge fastclock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      presc      <= '0;
      ones       <= '0;
      tens       <= '0;
      snap_ones  <= '0;
      snap_tens  <= '0;
      ss_prev    <= 1'b1;
      lap_prev   <= 1'b1;
      clr_prev   <= 1'b1;
      disp_ones  <= '0;
      disp_tens  <= '0;
      live_ones  <= '0;
      live_tens  <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      ones       <= ones_nxt;
      tens       <= tens_nxt;
      snap_ones  <= snap_ones_nxt;
      snap_tens  <= snap_tens_nxt;
      ss_prev    <= start_stop;
      lap_prev   <= lap;
      clr_prev   <= clear;
      disp_ones  <= (state_nxt == S_LAP) ? snap_ones_nxt : ones_nxt;
      disp_tens  <= (state_nxt == S_LAP) ? snap_tens_nxt : tens_nxt;
      live_ones  <= ones_nxt;
      live_tens  <= tens_nxt;
      running    <= (state_nxt == S_RUN) || (state_nxt == S_LAP);
      lap_active <= (state_nxt == S_LAP);
      wrap       <= wrap_nxt;
    end
  end

endmodule
